// File: rtl/alu_mc.sv
// ============================================================================
//  Module      : alu_mc
//  Description : Multi-cycle ALU with start/busy/done handshake; single-cycle
//                logic ops and an iterative shift-add unsigned multiply.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module alu_mc #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [3:0]            opcode,
   input  logic [DATA_WIDTH-1:0] in_a,
   input  logic [DATA_WIDTH-1:0] in_b,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] alu_out,
   output logic                  zero,
   output logic                  carry
);

   localparam int c_cnt_w = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DATA_WIDTH - 1);

   localparam logic [3:0] c_op_add  = 4'd2;
   localparam logic [3:0] c_op_and  = 4'd3;
   localparam logic [3:0] c_op_xor  = 4'd4;
   localparam logic [3:0] c_op_pasb = 4'd5;
   localparam logic [3:0] c_op_sub  = 4'd8;
   localparam logic [3:0] c_op_or   = 4'd9;
   localparam logic [3:0] c_op_shl  = 4'd10;
   localparam logic [3:0] c_op_shr  = 4'd11;
   localparam logic [3:0] c_op_mul  = 4'd12;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_MUL  = 1'b1
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic [DATA_WIDTH-1:0]   r_alu_out;
   logic                    r_zero;
   logic                    r_carry;
   logic                    r_done;
   logic                    r_zero_hold;
   logic [2*DATA_WIDTH-1:0] r_mcand;
   logic [DATA_WIDTH-1:0]   r_mplier;
   logic [2*DATA_WIDTH-1:0] r_acc;
   logic [c_cnt_w-1:0]      r_count;

   logic                    w_accept;
   logic                    w_is_mul;
   logic                    w_last;
   logic [DATA_WIDTH:0]     w_sum;
   logic [DATA_WIDTH:0]     w_diff;
   logic [DATA_WIDTH-1:0]   w_result;
   logic                    w_carry;
   logic [2*DATA_WIDTH-1:0] w_addend;
   logic [2*DATA_WIDTH-1:0] w_acc_next;

   assign w_is_mul = (opcode == c_op_mul);
   assign w_accept = start && (r_state == S_IDLE);
   assign w_last   = (r_count == c_last);

   // ------------------------------------------------------------------------
   // State register and next-state logic
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: if (w_accept && w_is_mul) w_state_next = S_MUL;
         S_MUL:  if (w_last)               w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Single-cycle operations
   // ------------------------------------------------------------------------
   always_comb begin
      w_sum    = {1'b0, in_a} + {1'b0, in_b};
      w_diff   = {1'b0, in_a} - {1'b0, in_b};
      w_result = in_a;
      w_carry  = 1'b0;
      case (opcode)
         c_op_add: begin
            w_result = w_sum[DATA_WIDTH-1:0];
            w_carry  = w_sum[DATA_WIDTH];
         end
         c_op_and:  w_result = in_a & in_b;
         c_op_xor:  w_result = in_a ^ in_b;
         c_op_pasb: w_result = in_b;
         c_op_sub: begin
            // The extra MSB of the widened difference is the unsigned borrow.
            w_result = w_diff[DATA_WIDTH-1:0];
            w_carry  = w_diff[DATA_WIDTH];
         end
         c_op_or:   w_result = in_a | in_b;
         c_op_shl: begin
            w_result = {in_a[DATA_WIDTH-2:0], 1'b0};
            w_carry  = in_a[DATA_WIDTH-1];
         end
         c_op_shr: begin
            w_result = {1'b0, in_a[DATA_WIDTH-1:1]};
            w_carry  = in_a[0];
         end
         default: begin
            w_result = in_a;
            w_carry  = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Shift-add multiply step
   // ------------------------------------------------------------------------
   assign w_addend   = r_mplier[0] ? r_mcand : '0;
   assign w_acc_next = r_acc + w_addend;

   // ------------------------------------------------------------------------
   // Datapath and result registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_alu_out   <= '0;
         r_zero      <= 1'b0;
         r_carry     <= 1'b0;
         r_done      <= 1'b0;
         r_zero_hold <= 1'b0;
         r_mcand     <= '0;
         r_mplier    <= '0;
         r_acc       <= '0;
         r_count     <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (w_is_mul) begin
                     // zero is held privately so visible outputs move only on done.
                     r_mcand     <= {{DATA_WIDTH{1'b0}}, in_a};
                     r_mplier    <= in_b;
                     r_acc       <= '0;
                     r_count     <= '0;
                     r_zero_hold <= (in_a == '0);
                  end else begin
                     r_alu_out <= w_result;
                     r_carry   <= w_carry;
                     r_zero    <= (in_a == '0);
                     r_done    <= 1'b1;
                  end
               end
            end
            S_MUL: begin
               r_acc    <= w_acc_next;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_count  <= r_count + c_cnt_w'(1);
               if (w_last) begin
                  r_alu_out <= w_acc_next[DATA_WIDTH-1:0];
                  r_carry   <= |w_acc_next[2*DATA_WIDTH-1:DATA_WIDTH];
                  r_zero    <= r_zero_hold;
                  r_done    <= 1'b1;
               end
            end
            default: r_done <= 1'b0;
         endcase
      end
   end

   assign busy    = (r_state == S_MUL);
   assign done    = r_done;
   assign alu_out = r_alu_out;
   assign zero    = r_zero;
   assign carry   = r_carry;

endmodule

`default_nettype wire

// File: tb/tb_alu_mc.sv
// ============================================================================
//  Module      : tb_alu_mc
//  Description : Self-checking bench for alu_mc (8-bit with model, 16-bit directed).
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_alu_mc;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  opcode = 4'd0;
   logic [7:0]  in_a = 8'd0;
   logic [7:0]  in_b = 8'd0;
   logic        busy, done, zero, carry;
   logic [7:0]  alu_out;

   logic        start16 = 1'b0;
   logic [3:0]  opcode16 = 4'd0;
   logic [15:0] in_a16 = 16'd0;
   logic [15:0] in_b16 = 16'd0;
   logic        busy16, done16, zero16, carry16;
   logic [15:0] alu_out16;

   int n_assert = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   always #5 clk = ~clk;

   alu_mc #(.DATA_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .opcode(opcode),
      .in_a(in_a), .in_b(in_b), .busy(busy), .done(done),
      .alu_out(alu_out), .zero(zero), .carry(carry)
   );

   alu_mc #(.DATA_WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .opcode(opcode16),
      .in_a(in_a16), .in_b(in_b16), .busy(busy16), .done(done16),
      .alu_out(alu_out16), .zero(zero16), .carry(carry16)
   );

   task automatic chk(input string name, input longint act, input longint exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Arithmetic reference: returns {carry, result} with result in bits [15:0].
   function automatic logic [16:0] ref_op(input int op, input longint a, input longint b,
                                          input int w);
      longint m = (longint'(1) << w) - 1;
      longint r = a;
      bit     c = 1'b0;
      case (op)
         2:  begin r = a + b; c = (r > m); end
         3:  r = a & b;
         4:  r = a ^ b;
         5:  r = b;
         8:  begin r = a - b; c = (a < b); end
         9:  r = a | b;
         10: begin r = a * 2; c = (a >= (longint'(1) << (w - 1))); end
         11: begin r = a / 2; c = (a % 2) == 1; end
         12: begin r = a * b; c = (r > m); end
         default: r = a;
      endcase
      return {c, 16'(r & m)};
   endfunction

   // Cycle-level model of the 8-bit instance
   logic [16:0] m_res;
   int          m_busy = 0;
   logic        m_done = 1'b0, m_zero = 1'b0, m_carry = 1'b0;
   logic [7:0]  m_out = 8'd0;
   logic [7:0]  p_out = 8'd0;
   logic        p_carry = 1'b0, p_zero = 1'b0;

   always_comb m_res = ref_op(int'(opcode), longint'(in_a), longint'(in_b), 8);

   always @(posedge clk) begin
      if (rst) begin
         m_busy <= 0; m_done <= 1'b0; m_out <= 8'd0; m_zero <= 1'b0; m_carry <= 1'b0;
      end else if (m_busy > 0) begin
         m_busy <= m_busy - 1;
         m_done <= (m_busy == 1);
         if (m_busy == 1) begin
            m_out <= p_out; m_carry <= p_carry; m_zero <= p_zero;
         end
      end else begin
         m_done <= start && (opcode != 4'd12);
         if (start && opcode == 4'd12) begin
            m_busy  <= 8;
            p_out   <= m_res[7:0];
            p_carry <= m_res[16];
            p_zero  <= (in_a == 8'd0);
         end else if (start) begin
            m_out   <= m_res[7:0];
            m_carry <= m_res[16];
            m_zero  <= (in_a == 8'd0);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model.done",  done,    m_done);
         chk("model.busy",  busy,    m_busy > 0);
         chk("model.out",   alu_out, m_out);
         chk("model.zero",  zero,    m_zero);
         chk("model.carry", carry,   m_carry);
      end
   end

   task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      start = 1'b1; opcode = op; in_a = a; in_b = b;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Counts negedges until done; also counts busy cycles seen on the way.
   task automatic wait_done(input int max, output int lat, output int nbusy);
      lat = 0; nbusy = 0;
      do begin
         @(negedge clk);
         lat++;
         if (busy) nbusy++;
      end while (!done && lat < max);
      if (!done) chk("wait_done.timeout", 0, 1);
   endtask

   logic [7:0] leg_exp [8] = '{8'h42, 8'h42, 8'hC8, 8'h02, 8'hC4, 8'h86, 8'h42, 8'h42};
   logic [3:0] b2b_op  [4] = '{4'd2, 4'd9, 4'd4, 4'd8};
   logic [7:0] b2b_a   [4] = '{8'h01, 8'hF0, 8'hAA, 8'h10};
   logic [7:0] b2b_b   [4] = '{8'h02, 8'h0F, 8'hFF, 8'h01};
   logic [7:0] b2b_exp [4] = '{8'h03, 8'hFF, 8'h55, 8'h0F};

   initial begin
      int lat, nb, ndone, k;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      chk("reset.out",   alu_out, 0);
      chk("reset.busy",  busy,    0);
      chk("reset.done",  done,    0);
      chk("reset.out16", alu_out16, 0);

      for (int i = 0; i < 8; i++) begin
         issue(4'(i), 8'h42, 8'h86);
         @(negedge clk);
         chk("legacy.done",  done,    1);
         chk("legacy.out",   alu_out, leg_exp[i]);
         chk("legacy.zero",  zero,    0);
         chk("legacy.carry", carry,   0);
      end
      issue(4'd0, 8'h00, 8'h55);
      @(negedge clk);
      chk("passa0.out", alu_out, 8'h00);
      chk("passa0.zero", zero, 1);

      issue(4'd2, 8'hFF, 8'h01); @(negedge clk);
      chk("add.out", alu_out, 8'h00); chk("add.carry", carry, 1); chk("add.zero", zero, 0);
      issue(4'd8, 8'h05, 8'h07); @(negedge clk);
      chk("sub.out", alu_out, 8'hFE); chk("sub.carry", carry, 1);
      issue(4'd10, 8'h81, 8'h00); @(negedge clk);
      chk("shl.out", alu_out, 8'h02); chk("shl.carry", carry, 1);
      issue(4'd11, 8'h03, 8'h00); @(negedge clk);
      chk("shr.out", alu_out, 8'h01); chk("shr.carry", carry, 1);

      // start held high: one result per cycle
      start = 1'b1;
      for (int i = 0; i < 4; i++) begin
         opcode = b2b_op[i]; in_a = b2b_a[i]; in_b = b2b_b[i];
         @(posedge clk);
         @(negedge clk);
         chk("b2b.done", done, 1);
         chk("b2b.out", alu_out, b2b_exp[i]);
      end
      start = 1'b0;

      issue(4'd12, 8'h0D, 8'h0B);
      wait_done(40, lat, nb);
      chk("mul1.lat", lat, 9); chk("mul1.busy_cycles", nb, 8);
      chk("mul1.out", alu_out, 8'h8F); chk("mul1.carry", carry, 0);
      issue(4'd12, 8'h10, 8'h10);
      wait_done(40, lat, nb);
      chk("mul2.lat", lat, 9); chk("mul2.out", alu_out, 8'h00); chk("mul2.carry", carry, 1);

      // start during busy is dropped
      issue(4'd12, 8'h03, 8'h05);
      ndone = 0; k = 0;
      do begin
         @(negedge clk);
         k++;
         if (k == 3) begin start = 1'b1; opcode = 4'd2; in_a = 8'h01; in_b = 8'h01; end
         if (k == 4) start = 1'b0;
         if (done) ndone++;
      end while (!done && k < 40);
      chk("drop.lat", k, 9); chk("drop.ndone", ndone, 1); chk("drop.out", alu_out, 8'h0F);
      issue(4'd2, 8'h10, 8'h20);
      @(negedge clk);
      chk("after_mul.done", done, 1); chk("after_mul.out", alu_out, 8'h30);

      // reset in the middle of a multiply
      issue(4'd12, 8'h07, 8'h09);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("abort.out", alu_out, 0); chk("abort.busy", busy, 0);
      chk("abort.zero", zero, 0); chk("abort.carry", carry, 0); chk("abort.done", done, 0);
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("abort.no_done", ndone, 0);
      issue(4'd2, 8'h01, 8'h01);
      @(negedge clk);
      chk("post_abort.done", done, 1); chk("post_abort.out", alu_out, 8'h02);

      // 16-bit instance
      start16 = 1'b1; opcode16 = 4'd12; in_a16 = 16'h0100; in_b16 = 16'h0100;
      @(posedge clk);
      #1 start16 = 1'b0;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!done16 && lat < 60);
      chk("w16.mul.lat", lat, 17); chk("w16.mul.out", alu_out16, 16'h0000);
      chk("w16.mul.carry", carry16, 1);
      start16 = 1'b1; opcode16 = 4'd2; in_a16 = 16'hFFFF; in_b16 = 16'h0001;
      @(posedge clk);
      #1 start16 = 1'b0;
      @(negedge clk);
      chk("w16.add.done", done16, 1); chk("w16.add.out", alu_out16, 16'h0000);
      chk("w16.add.carry", carry16, 1); chk("w16.add.zero", zero16, 0);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/alu_mc.md
# alu_mc

Parametrised, multi-cycle successor to the VeriRISC 8-bit ALU. It keeps the legacy 3-bit opcode map and the in_a zero flag. It adds a registered result, a carry flag, SUB/OR/shift operations and an iterative shift-add multiply, all behind a start/busy/done handshake. It sits between the register file/accumulator and the CPU controller, which issues one operation per start pulse and samples alu_out, zero and carry on done.

## Interface
- data_width, default 8: operand and result width (≥2).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  request; accepted only when busy=0.
- opcode  in  4  operation select, sampled on the accepting edge.
- in_a  in  data_width  operand A, sampled on the accepting edge.
- in_b  in  data_width  operand B, sampled on the accepting edge.
- busy  out  1  multiply in progress; start ignored while high.
- done  out  1  one-cycle pulse; alu_out/zero/carry valid from this cycle.
- alu_out  out  data_width  registered result; held until next completion.
- zero  out  1  registered (in_a == 0) of the accepted operation.
- carry  out  1  registered carry/borrow/shift-out/overflow.

## Operation
- Opcode map (results truncated to data_width, carry as noted, else carry=0):
  - 0, 1, 6, 7, 13, 14, 15: PASSA, alu_out=in_a.
  - 2: ADD, {carry,alu_out} = in_a + in_b (data_width+1 bit sum).
  - 3: AND.
  - 4: XOR.
  - 5: PASSB, alu_out=in_b.
  - 8: SUB, alu_out = in_a − in_b mod 2^data_width; carry = borrow (in_a < in_b, unsigned).
  - 9: OR.
  - 10: SHL1, alu_out = in_a<<1; carry = in_a[MSB].
  - 11: SHR1 (logical), alu_out = in_a>>1; carry = in_a[0].
  - 12: MUL, alu_out = low half of in_a×in_b (unsigned); carry = 1 if high half ≠ 0.
- Opcodes 0–7 with opcode[3]=0 reproduce the legacy ALU exactly.
- zero is always (in_a == 0) of the accepted operands, independent of the result.
- FSM states:
  - IDLE: start=1 with a non-MUL opcode → compute combinationally, register the results, pulse done, stay in IDLE. start=1 with MUL → load the multiplicand, multiplier and a 2·data_width accumulator cleared to 0, register zero, go to MUL with count=0.
  - MUL: each cycle, if multiplier[0] add the shifted multiplicand into the accumulator; shift the multiplicand left and the multiplier right; count++. After data_width iterations, register alu_out/carry, pulse done, go to IDLE.
- Operands are captured internally. Changes to in_a/in_b/opcode during MUL have no effect.
- start while busy=1 is dropped, not queued.

## Timing
- Reset, synchronous: state=IDLE, busy=0, done=0, alu_out=0, zero=0, carry=0, multiply datapath cleared. Reset asserted during MUL aborts it; no done pulse is produced.
- Accepting edge E (start=1, busy=0):
  - Non-MUL: done=1 and results valid in the cycle after E (latency 1).
  - MUL: busy=1 for the data_width cycles after E. done=1, busy=0 and results valid in cycle E+data_width+1 (latency data_width+1; 9 for default width).
- done is high for exactly one cycle per accepted operation.
- Back-to-back:
  - start may be held high in IDLE, giving one non-MUL result per cycle.
  - In the done cycle of a MUL, busy=0, so a start in that cycle is accepted.
- Outputs change only on a done cycle or on reset.

## Test plan
- Legacy vectors, in_a=0x42, in_b=0x86, opcodes 0–7 → alu_out 42,42,C8,02,C4,86,42,42; zero=0, carry=0; done one cycle after each start. Then PASSA with in_a=0x00 → alu_out=00, zero=1.
- Carry/borrow:
  - ADD 0xFF+0x01 → alu_out=00, carry=1, zero=0.
  - SUB 0x05−0x07 → FE, carry=1.
  - SHL1 0x81 → 02, carry=1.
  - SHR1 0x03 → 01, carry=1.
- MUL 0x0D×0x0B → busy high for 8 cycles, done at cycle E+9, alu_out=8F, carry=0. MUL 0x10×0x10 → alu_out=00, carry=1.
- Start while busy: issue MUL 0x03×0x05, then pulse start with ADD during busy → only one done, with alu_out=0F. ADD issued in the done cycle → its own done one cycle later.
- Reset mid-MUL at iteration 4 → next cycle all outputs 0, busy=0, and no done follows. A subsequent ADD 0x01+0x01 → 02 with latency 1.
- Parametrisation: data_width=16, MUL 0x0100×0x0100 → alu_out=0000, carry=1, latency 17. ADD 0xFFFF+0x0001 → 0000, carry=1.
